// File: rtl/sampler_rle.sv
// Divided-rate channel sampler: masks disabled channel groups, packs the
// enabled ones toward bit 0 and optionally run-length encodes repeated samples.
module sampler_rle #(
  parameter  int CHLS  = 32,
  parameter  int GRP_W = 8,
  parameter  int DIV_W = 24,
  localparam int GRPS  = CHLS / GRP_W
) (
  input  logic             clk_i,
  input  logic             rst_in,
  input  logic [DIV_W-1:0] fdiv_i,
  input  logic             set_div_i,
  input  logic [GRPS-1:0]  grp_dis_i,
  input  logic             rle_en_i,
  input  logic             set_cfg_i,
  input  logic             run_i,
  input  logic [CHLS-1:0]  data_i,
  output logic [CHLS-1:0]  smpls_o,
  output logic             stb_o,
  output logic             rle_o
);

  localparam int CNT_W = CHLS - 1;
  localparam logic [CNT_W-1:0] RUN_MAX = '1;

  logic [DIV_W-1:0] r_div_q, r_div_d, cnt_q, cnt_d;
  logic [GRPS-1:0]  mask_q, mask_d;
  logic             rle_q, rle_d;
  logic             run_prev_q, run_prev_d;
  logic [CHLS-1:0]  last_q, last_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic             have_last_q, have_last_d;
  logic             pend_q, pend_d;
  logic [CHLS-1:0]  smpls_q, smpls_d;
  logic             stb_q, stb_d;
  logic             rle_out_q, rle_out_d;

  logic [CHLS-1:0]  packed_s;
  logic [CHLS-1:0]  grp_ext;
  int               pos;
  logic             tick, rle_act, stop;

  // Enabled groups are shifted down over the gaps left by disabled ones.
  always_comb begin
    packed_s = '0;
    grp_ext  = '0;
    pos      = 0;
    for (int g = 0; g < GRPS; g++) begin
      grp_ext              = '0;
      grp_ext[GRP_W-1:0]   = data_i[g*GRP_W +: GRP_W];
      if (!mask_q[g]) begin
        packed_s = packed_s | (grp_ext << (pos * GRP_W));
        pos      = pos + 1;
      end
    end
  end

  assign tick    = run_i && (cnt_q >= r_div_q) && !set_div_i;
  assign rle_act = rle_q && (r_div_q != '0);
  assign stop    = run_prev_q && !run_i;

  always_comb begin
    r_div_d     = set_div_i ? fdiv_i : r_div_q;
    cnt_d       = cnt_q;
    mask_d      = mask_q;
    rle_d       = rle_q;
    run_prev_d  = run_i;
    last_d      = last_q;
    run_cnt_d   = run_cnt_q;
    have_last_d = have_last_q;
    pend_d      = pend_q;
    smpls_d     = smpls_q;
    stb_d       = 1'b0;
    rle_out_d   = 1'b0;

    if (set_div_i || !run_i || tick) cnt_d = '0;
    else                             cnt_d = cnt_q + 1'b1;

    if (set_cfg_i) begin
      // New configuration discards any partial run, including an owed value.
      mask_d      = grp_dis_i;
      rle_d       = rle_en_i;
      have_last_d = 1'b0;
      run_cnt_d   = '0;
      pend_d      = 1'b0;
    end else if (pend_q) begin
      stb_d   = 1'b1;
      smpls_d = last_q;
      pend_d  = 1'b0;
      if (stop) begin
        have_last_d = 1'b0;
        run_cnt_d   = '0;
      end
    end else if (stop) begin
      if (rle_act && run_cnt_q != '0) begin
        stb_d     = 1'b1;
        rle_out_d = 1'b1;
        smpls_d   = {1'b0, run_cnt_q};
      end
      have_last_d = 1'b0;
      run_cnt_d   = '0;
    end else if (tick) begin
      if (!rle_act) begin
        stb_d   = 1'b1;
        smpls_d = packed_s;
      end else if (!have_last_q) begin
        stb_d       = 1'b1;
        smpls_d     = packed_s;
        last_d      = packed_s;
        have_last_d = 1'b1;
        run_cnt_d   = '0;
      end else if (packed_s == last_q) begin
        if (run_cnt_q != RUN_MAX) begin
          run_cnt_d = run_cnt_q + 1'b1;
        end else begin
          // Saturated run: flush it; the current sample starts the next run.
          stb_d     = 1'b1;
          rle_out_d = 1'b1;
          smpls_d   = {1'b0, RUN_MAX};
          run_cnt_d = CNT_W'(1);
        end
      end else if (run_cnt_q == '0) begin
        stb_d   = 1'b1;
        smpls_d = packed_s;
        last_d  = packed_s;
      end else begin
        stb_d     = 1'b1;
        rle_out_d = 1'b1;
        smpls_d   = {1'b0, run_cnt_q};
        last_d    = packed_s;
        run_cnt_d = '0;
        pend_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      r_div_q     <= '0;
      cnt_q       <= '0;
      mask_q      <= '0;
      rle_q       <= 1'b0;
      run_prev_q  <= 1'b0;
      last_q      <= '0;
      run_cnt_q   <= '0;
      have_last_q <= 1'b0;
      pend_q      <= 1'b0;
      smpls_q     <= '0;
      stb_q       <= 1'b0;
      rle_out_q   <= 1'b0;
    end else begin
      r_div_q     <= r_div_d;
      cnt_q       <= cnt_d;
      mask_q      <= mask_d;
      rle_q       <= rle_d;
      run_prev_q  <= run_prev_d;
      last_q      <= last_d;
      run_cnt_q   <= run_cnt_d;
      have_last_q <= have_last_d;
      pend_q      <= pend_d;
      smpls_q     <= smpls_d;
      stb_q       <= stb_d;
      rle_out_q   <= rle_out_d;
    end
  end

  assign smpls_o = smpls_q;
  assign stb_o   = stb_q;
  assign rle_o   = rle_out_q;

endmodule

// File: tb/tb_sampler_rle.sv
// Directed bench for sampler_rle: a 32-channel instance for divider, packing
// and RLE cases, and an 8-channel instance for run-counter saturation.
module tb_sampler_rle;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] fdiv;
  logic        set_div, rle_en, set_cfg, run;
  logic [3:0]  grp_dis;
  logic [31:0] data, smpls;
  logic        stb, rle;

  logic [23:0] fdiv8;
  logic        set_div8, rle_en8, set_cfg8, run8;
  logic [0:0]  grp_dis8;
  logic [7:0]  data8, smpls8;
  logic        stb8, rle8;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [32:0] mon_q[$];
  int          mon_cyc[$];
  logic [8:0]  mon8_q[$];
  logic [32:0] exp_q[$];
  logic [8:0]  exp8_q[$];
  logic [31:0] t4_samp [0:4];

  sampler_rle u_dut (
    .clk_i(clk), .rst_in(rst_n), .fdiv_i(fdiv), .set_div_i(set_div),
    .grp_dis_i(grp_dis), .rle_en_i(rle_en), .set_cfg_i(set_cfg), .run_i(run),
    .data_i(data), .smpls_o(smpls), .stb_o(stb), .rle_o(rle)
  );

  sampler_rle #(.CHLS(8), .GRP_W(8), .DIV_W(24)) u_dut8 (
    .clk_i(clk), .rst_in(rst_n), .fdiv_i(fdiv8), .set_div_i(set_div8),
    .grp_dis_i(grp_dis8), .rle_en_i(rle_en8), .set_cfg_i(set_cfg8), .run_i(run8),
    .data_i(data8), .smpls_o(smpls8), .stb_o(stb8), .rle_o(rle8)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // capture every emitted word with the cycle it appeared in
  always @(negedge clk) begin
    if (stb === 1'b1) begin
      mon_q.push_back({rle, smpls});
      mon_cyc.push_back(cyc);
    end
    if (stb8 === 1'b1) mon8_q.push_back({rle8, smpls8});
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_stb(input string tag);
    int n = 0;
    while (stb !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check(tag, {63'd0, stb}, 64'd1);
  endtask

  task automatic cmp_words(input string tag);
    check({tag, "_n"}, mon_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_w%0d", tag, i), (i < mon_q.size()) ? mon_q[i] : 33'bx, exp_q[i]);
  endtask

  initial begin
    rst_n = 1'b0; fdiv = '0; set_div = 0; rle_en = 0; set_cfg = 0; run = 0;
    grp_dis = '0; data = '0;
    fdiv8 = '0; set_div8 = 0; rle_en8 = 0; set_cfg8 = 0; run8 = 0;
    grp_dis8 = '0; data8 = '0;
    t4_samp[0] = 32'd7; t4_samp[1] = 32'd7; t4_samp[2] = 32'd7;
    t4_samp[3] = 32'd7; t4_samp[4] = 32'd9;
    repeat (3) step();

    check("rst_stb", stb, 0);
    check("rst_rle", rle, 0);
    check("rst_smpls", smpls, 0);
    check("rst_stb8", stb8, 0);

    // 1: pass-through, r_div=0 -> strobe every cycle
    rst_n = 1'b1; run = 1'b1; data = 32'hA5A5_0001;
    step();
    for (int i = 0; i < 4; i++) begin
      check("t1_stb", stb, 1);
      check("t1_smpls", smpls, 32'hA5A5_0001);
      check("t1_rle", rle, 0);
      step();
    end

    // 2: divide by 4, first strobe five cycles after the load strobe
    fdiv = 24'd3; set_div = 1'b1;
    step();
    set_div = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      check($sformatf("t2_stb_k%0d", k), stb, (k == 4 || k == 8));
      step();
    end

    // 3: group masking and packing
    data = 32'h4433_2211; grp_dis = 4'b0101; set_cfg = 1'b1;
    step();
    set_cfg = 1'b0;
    wait_stb("t3a_stb");
    check("t3a_smpls", smpls, 32'h0000_4422);
    check("t3a_rle", rle, 0);
    grp_dis = 4'b0011; set_cfg = 1'b1;
    step();
    set_cfg = 1'b0;
    wait_stb("t3b_stb");
    check("t3b_smpls", smpls, 32'h0000_4433);
    grp_dis = 4'b1111; set_cfg = 1'b1;
    step();
    set_cfg = 1'b0;
    wait_stb("t3c_stb");
    check("t3c_smpls", smpls, 32'h0);

    // 4: RLE, r_div=1: 7,7,7,7,9 -> value 7, count 3, value 9
    run = 1'b0; grp_dis = '0;
    step(); step();
    fdiv = 24'd1; set_div = 1'b1; rle_en = 1'b1; set_cfg = 1'b1;
    step();
    set_div = 1'b0; set_cfg = 1'b0;
    step();
    mon_q.delete(); mon_cyc.delete();
    run = 1'b1;
    for (int i = 0; i < 10; i++) begin
      data = t4_samp[i/2];
      step();
    end
    run = 1'b0;
    repeat (4) step();
    exp_q.delete();
    exp_q.push_back({1'b0, 32'd7});
    exp_q.push_back({1'b1, 32'd3});
    exp_q.push_back({1'b0, 32'd9});
    cmp_words("t4");
    if (mon_cyc.size() >= 3) check("t4_gap", mon_cyc[2] - mon_cyc[1], 1);

    // 5: 8-channel saturation: 130 equal ticks -> value, count 127, count 2
    fdiv8 = 24'd1; set_div8 = 1'b1; rle_en8 = 1'b1; set_cfg8 = 1'b1;
    step();
    set_div8 = 1'b0; set_cfg8 = 1'b0;
    step();
    mon8_q.delete();
    run8 = 1'b1; data8 = 8'h3C;
    repeat (260) step();
    run8 = 1'b0;
    repeat (4) step();
    exp8_q.delete();
    exp8_q.push_back({1'b0, 8'h3C});
    exp8_q.push_back({1'b1, 8'd127});
    exp8_q.push_back({1'b1, 8'd2});
    check("t5_n", mon8_q.size(), exp8_q.size());
    for (int i = 0; i < exp8_q.size(); i++)
      check($sformatf("t5_w%0d", i), (i < mon8_q.size()) ? mon8_q[i] : 9'bx, exp8_q[i]);

    // 6: stop with run_cnt=5 flushes exactly one count word
    mon_q.delete(); mon_cyc.delete();
    data = 32'h55; run = 1'b1;
    repeat (12) step();
    run = 1'b0;
    repeat (4) step();
    exp_q.delete();
    exp_q.push_back({1'b0, 32'h55});
    exp_q.push_back({1'b1, 32'd5});
    cmp_words("t6");

    // next run restarts with a value word; then async reset mid-run
    run = 1'b1;
    step(); step();
    check("t6_restart_stb", stb, 1);
    check("t6_restart_rle", rle, 0);
    check("t6_restart_smpls", smpls, 32'h55);
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_stb", stb, 0);
    check("t6_rst_smpls", smpls, 0);
    check("t6_rst_rle", rle, 0);
    run = 1'b0;
    step(); step();
    rst_n = 1'b1;
    mon_q.delete();
    repeat (4) step();
    check("t6_no_flush", mon_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
